// File: rtl/branch_seq_pkg.sv
// Shared control-unit definitions used by the branch sequencer:
// sequencer states, opcode constants, IR field positions, condition
// encodings and the state-to-strobe decode.
package branch_seq_pkg;

    // Sequencer states; T1/T2 (fetch) are owned by the main control unit.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T3   = 3'd1,
        S_T4   = 3'd2,
        S_T5   = 3'd3,
        S_T6   = 3'd4,
        S_DONE = 3'd5
    } state_t;

    // Opcode map (ir[31:27]).
    localparam logic [4:0] OPC_LD   = 5'b00000;
    localparam logic [4:0] OPC_LDI  = 5'b00001;
    localparam logic [4:0] OPC_ST   = 5'b00010;
    localparam logic [4:0] OPC_ADD  = 5'b00011;
    localparam logic [4:0] OPC_SUB  = 5'b00100;
    localparam logic [4:0] OPC_ADDI = 5'b01100;
    localparam logic [4:0] OPC_BR   = 5'b10010;
    localparam logic [4:0] OPC_JR   = 5'b10011;
    localparam logic [4:0] OPC_JAL  = 5'b10100;

    // IR field positions.
    localparam int OPC_HI = 31;
    localparam int OPC_LO = 27;
    localparam int RA_HI  = 26;
    localparam int RA_LO  = 23;
    localparam int C2_HI  = 20;
    localparam int C2_LO  = 19;
    localparam int C_HI   = 18;
    localparam int C_LO   = 0;

    // Condition select encodings presented to the condition logic.
    typedef enum logic [1:0] {
        COND_ZERO    = 2'b00,
        COND_NONZERO = 2'b01,
        COND_POS     = 2'b10,
        COND_NEG     = 2'b11
    } cond_t;

    // Control strobes produced by the sequencer.
    typedef struct packed {
        logic gra;
        logic rout;
        logic con_in;
        logic pc_out;
        logic y_in;
        logic c_out;
        logic add;
        logic z_in;
        logic zlow_out;
        logic pc_in;
        logic done;
        logic busy;
    } strobe_t;

    // Moore decode: strobes depend on state only (PCin additionally on the
    // branch decision that was latched back in T3).
    function automatic strobe_t decode_strobes(input state_t s, input logic taken);
        strobe_t d;
        d = '0;
        d.busy = (s != S_IDLE);
        case (s)
            S_T3: begin
                d.gra    = 1'b1;
                d.rout   = 1'b1;
                d.con_in = 1'b1;
            end
            S_T4: begin
                d.pc_out = 1'b1;
                d.y_in   = 1'b1;
            end
            S_T5: begin
                d.c_out = 1'b1;
                d.add   = 1'b1;
                d.z_in  = 1'b1;
            end
            S_T6: begin
                d.zlow_out = 1'b1;
                d.pc_in    = taken;
            end
            S_DONE: d.done = 1'b1;
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/branch_seq_if.sv
// Handshake and control-strobe bundle between the main control unit
// (master) and the branch sequencer (slave).
interface branch_seq_if;
    logic        start;
    logic [31:0] ir;
    logic        con_q;
    logic [1:0]  cond_sel;
    logic [3:0]  ra_sel;
    logic        Gra;
    logic        Rout;
    logic        CONin;
    logic        PCout;
    logic        Yin;
    logic        Cout;
    logic [31:0] c_sext;
    logic        ADD;
    logic        Zin;
    logic        Zlowout;
    logic        PCin;
    logic        busy;
    logic        taken;
    logic        done;
    logic        illegal;

    modport master (
        output start, ir, con_q,
        input  cond_sel, ra_sel, Gra, Rout, CONin, PCout, Yin, Cout, c_sext,
               ADD, Zin, Zlowout, PCin, busy, taken, done, illegal
    );

    modport slave (
        input  start, ir, con_q,
        output cond_sel, ra_sel, Gra, Rout, CONin, PCout, Yin, Cout, c_sext,
               ADD, Zin, Zlowout, PCin, busy, taken, done, illegal
    );
endinterface

// File: rtl/branch_seq.sv
// Branch control-step sequencer: runs T3..T6 for brzr/brnz/brpl/brmi,
// latching the condition in T3 and loading PC with PC + sext(C) in T6
// only when the branch is taken. All strobes are registered.
module branch_seq #(
    parameter logic [4:0] OPC_BR     = branch_seq_pkg::OPC_BR,
    parameter bit         EARLY_EXIT = 1'b1,
    parameter int         IMM_W      = 19
) (
    input  logic         clk,
    input  logic         clr,
    branch_seq_if.slave  ctl
);
    import branch_seq_pkg::*;

    state_t      state;
    state_t      nxt;
    logic [31:0] ir_q;
    logic        taken;
    logic        illegal;
    strobe_t     strb;
    logic        opc_ok;
    logic        unused_bits;

    assign opc_ok = (ctl.ir[OPC_HI:OPC_LO] == OPC_BR);

    // Next-state selection; a not-taken branch may skip the PC update steps.
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  if (ctl.start && opc_ok) nxt = S_T3;
            S_T3:    nxt = S_T4;
            S_T4:    nxt = (EARLY_EXIT && !taken) ? S_DONE : S_T5;
            S_T5:    nxt = S_T6;
            S_T6:    nxt = S_DONE;
            S_DONE:  nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    // State, captured instruction, branch decision and registered strobes.
    always_ff @(posedge clk) begin
        if (clr) begin
            state   <= S_IDLE;
            ir_q    <= '0;
            taken   <= 1'b0;
            illegal <= 1'b0;
            strb    <= '0;
        end else begin
            state   <= nxt;
            strb    <= decode_strobes(nxt, taken);
            illegal <= (state == S_IDLE) && ctl.start && !opc_ok;
            if ((state == S_IDLE) && ctl.start && opc_ok)
                ir_q <= ctl.ir;
            if (state == S_T3)
                taken <= ctl.con_q;
        end
    end

    // Field decodes come straight from the captured IR, so they stay put
    // from T3 until the next accepted start.
    assign ctl.cond_sel = ir_q[C2_HI:C2_LO];
    assign ctl.ra_sel   = ir_q[RA_HI:RA_LO];
    assign ctl.c_sext   = {{(32-IMM_W){ir_q[IMM_W-1]}}, ir_q[IMM_W-1:0]};

    assign ctl.Gra     = strb.gra;
    assign ctl.Rout    = strb.rout;
    assign ctl.CONin   = strb.con_in;
    assign ctl.PCout   = strb.pc_out;
    assign ctl.Yin     = strb.y_in;
    assign ctl.Cout    = strb.c_out;
    assign ctl.ADD     = strb.add;
    assign ctl.Zin     = strb.z_in;
    assign ctl.Zlowout = strb.zlow_out;
    assign ctl.PCin    = strb.pc_in;
    assign ctl.done    = strb.done;
    assign ctl.busy    = strb.busy;
    assign ctl.taken   = taken;
    assign ctl.illegal = illegal;

    // Opcode and spare bits of the captured IR are not needed after capture.
    assign unused_bits = ^{ir_q[31:27], ir_q[22:21]};

endmodule

// File: tb/tb_branch_seq.sv
// Directed bench for branch_seq: two instances (early exit on and off)
// share the same stimulus; per-cycle strobe vectors and IR field decodes
// are compared against hand-computed values.
module tb_branch_seq;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic [31:0] ir;
    logic        con_q;

    int checks   = 0;
    int failures = 0;
    int bus_viol = 0;

    always #5 clk = ~clk;

    branch_seq_if if_ee();
    branch_seq_if if_ne();

    assign if_ee.start = start;
    assign if_ee.ir    = ir;
    assign if_ee.con_q = con_q;
    assign if_ne.start = start;
    assign if_ne.ir    = ir;
    assign if_ne.con_q = con_q;

    branch_seq #(.EARLY_EXIT(1'b1)) dut_ee (.clk(clk), .clr(clr), .ctl(if_ee));
    branch_seq #(.EARLY_EXIT(1'b0)) dut_ne (.clk(clk), .clr(clr), .ctl(if_ne));

    // Strobe vector bit order:
    // [12]busy [11]done [10]illegal [9]PCin [8]Zlowout [7]Zin [6]ADD
    // [5]Cout [4]Yin [3]PCout [2]CONin [1]Rout [0]Gra
    logic [12:0] vec_ee;
    logic [12:0] vec_ne;
    assign vec_ee = {if_ee.busy, if_ee.done, if_ee.illegal, if_ee.PCin, if_ee.Zlowout, if_ee.Zin,
                     if_ee.ADD, if_ee.Cout, if_ee.Yin, if_ee.PCout, if_ee.CONin, if_ee.Rout, if_ee.Gra};
    assign vec_ne = {if_ne.busy, if_ne.done, if_ne.illegal, if_ne.PCin, if_ne.Zlowout, if_ne.Zin,
                     if_ne.ADD, if_ne.Cout, if_ne.Yin, if_ne.PCout, if_ne.CONin, if_ne.Rout, if_ne.Gra};

    localparam logic [12:0] V_IDLE = 13'h0000;
    localparam logic [12:0] V_T3   = 13'h1007;
    localparam logic [12:0] V_T4   = 13'h1018;
    localparam logic [12:0] V_T5   = 13'h10E0;
    localparam logic [12:0] V_T6T  = 13'h1300;
    localparam logic [12:0] V_T6N  = 13'h1100;
    localparam logic [12:0] V_DONE = 13'h1800;
    localparam logic [12:0] V_ILL  = 13'h0400;

    logic [12:0] exp_ee [1:6];
    logic [12:0] exp_ne [1:6];

    // At most one bus driver per cycle, on both instances.
    always @(negedge clk) begin
        if ($countones({if_ee.Rout, if_ee.PCout, if_ee.Cout, if_ee.Zlowout}) > 1) bus_viol++;
        if ($countones({if_ne.Rout, if_ne.PCout, if_ne.Cout, if_ne.Zlowout}) > 1) bus_viol++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one start and compare six cycles of strobes on both instances.
    // mid_cyc: cycle in which a second start (mid_ir) is raised; clr_cyc:
    // cycle in which clr is raised. Zero disables either.
    task automatic run(input string name, input logic [31:0] instr, input logic con,
                       input int mid_cyc, input logic [31:0] mid_ir, input int clr_cyc);
        start = 1'b1;
        ir    = instr;
        con_q = con;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk($sformatf("%s_ee_c%0d", name, k), {19'd0, vec_ee}, {19'd0, exp_ee[k]});
            chk($sformatf("%s_ne_c%0d", name, k), {19'd0, vec_ne}, {19'd0, exp_ne[k]});
            start = (k == mid_cyc);
            if (k == mid_cyc) ir = mid_ir;
            clr = (k == clr_cyc);
        end
        start = 1'b0;
        clr   = 1'b0;
    endtask

    task automatic fields(input string name, input logic [1:0] cs, input logic [3:0] ra,
                          input logic [31:0] cx, input logic tk);
        chk({name, "_ee_cond"}, {30'd0, if_ee.cond_sel}, {30'd0, cs});
        chk({name, "_ee_ra"},   {28'd0, if_ee.ra_sel},   {28'd0, ra});
        chk({name, "_ee_csext"}, if_ee.c_sext, cx);
        chk({name, "_ee_taken"}, {31'd0, if_ee.taken}, {31'd0, tk});
        chk({name, "_ne_cond"}, {30'd0, if_ne.cond_sel}, {30'd0, cs});
        chk({name, "_ne_ra"},   {28'd0, if_ne.ra_sel},   {28'd0, ra});
        chk({name, "_ne_csext"}, if_ne.c_sext, cx);
        chk({name, "_ne_taken"}, {31'd0, if_ne.taken}, {31'd0, tk});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr   = 1'b1;
        start = 1'b0;
        ir    = 32'h0;
        con_q = 1'b0;
        @(negedge clk);
        @(negedge clk);
        // start presented while clr is still high must be ignored
        start = 1'b1;
        ir    = 32'h91000023;
        @(negedge clk);
        chk("rst_vec_ee", {19'd0, vec_ee}, {19'd0, V_IDLE});
        chk("rst_vec_ne", {19'd0, vec_ne}, {19'd0, V_IDLE});
        fields("rst", 2'b00, 4'd0, 32'h0, 1'b0);
        clr   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("idle_vec_ee", {19'd0, vec_ee}, {19'd0, V_IDLE});
        chk("idle_vec_ne", {19'd0, vec_ne}, {19'd0, V_IDLE});

        // brzr R2, C=0x23, taken
        exp_ee = '{V_T3, V_T4, V_T5, V_T6T, V_DONE, V_IDLE};
        exp_ne = exp_ee;
        run("brzr", 32'h91000023, 1'b1, 0, 32'h0, 0);
        fields("brzr", 2'b00, 4'd2, 32'h00000023, 1'b1);

        // brmi, C=-4, taken
        run("brmi", 32'h911FFFFC, 1'b1, 0, 32'h0, 0);
        fields("brmi", 2'b11, 4'd2, 32'hFFFFFFFC, 1'b1);

        // brpl, C=5, taken
        run("brpl", 32'h91100005, 1'b1, 0, 32'h0, 0);
        fields("brpl", 2'b10, 4'd2, 32'h00000005, 1'b1);

        // brnz, not taken: early exit vs full sequence without PCin
        exp_ee = '{V_T3, V_T4, V_DONE, V_IDLE, V_IDLE, V_IDLE};
        exp_ne = '{V_T3, V_T4, V_T5, V_T6N, V_DONE, V_IDLE};
        run("brnz", 32'h91080010, 1'b0, 0, 32'h0, 0);
        fields("brnz", 2'b01, 4'd2, 32'h00000010, 1'b0);

        // non-branch opcode: illegal pulse only, captured IR and taken untouched
        exp_ee = '{V_ILL, V_IDLE, V_IDLE, V_IDLE, V_IDLE, V_IDLE};
        exp_ne = exp_ee;
        run("illegal", 32'h18000000, 1'b1, 0, 32'h0, 0);
        fields("illegal", 2'b01, 4'd2, 32'h00000010, 1'b0);

        // second start during T4 is ignored
        exp_ee = '{V_T3, V_T4, V_T5, V_T6T, V_DONE, V_IDLE};
        exp_ne = exp_ee;
        run("busy_start", 32'h91000023, 1'b1, 2, 32'h97800000, 0);
        fields("busy_start", 2'b00, 4'd2, 32'h00000023, 1'b1);

        // clr during T5 aborts: no PCin, no done, IR and taken cleared
        exp_ee = '{V_T3, V_T4, V_T5, V_IDLE, V_IDLE, V_IDLE};
        exp_ne = exp_ee;
        run("clr_t5", 32'h91000023, 1'b1, 0, 32'h0, 3);
        fields("clr_t5", 2'b00, 4'd0, 32'h0, 1'b0);

        // fresh start after abort completes normally
        exp_ee = '{V_T3, V_T4, V_T5, V_T6T, V_DONE, V_IDLE};
        exp_ne = exp_ee;
        run("after_clr", 32'h911FFFFC, 1'b1, 0, 32'h0, 0);
        fields("after_clr", 2'b11, 4'd2, 32'hFFFFFFFC, 1'b1);

        chk("bus_onehot", bus_viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
